// File: rtl/regfile_wb_arbiter.sv
// Write-port owner for the register file: round-robin arbiter between ALU (A) and load (B)
// writeback plus a clear sequencer. Optional REGFILE_WB_PENDING_EN adds pending_mask/collision.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_reg,
    input  logic [DATA_W-1:0]   a_data,

    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_reg,
    input  logic [DATA_W-1:0]   b_data,

    input  logic                stall,
    input  logic                init_start,
    output logic                init_done,

    output logic                RegWrite,
    output logic [ADDR_W-1:0]   WriteReg,
    output logic [DATA_W-1:0]   WriteData,
    output logic                grant_id,
`ifdef REGFILE_WB_PENDING_EN
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                collision,
`endif
    output logic [CNT_W-1:0]    wr_count
);

    typedef enum logic [1:0] {StIdle, StInit, StDone} state_e;

    state_e              state_q, state_d;
    logic                prio_q, prio_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]   write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic                grant_id_q, grant_id_d;
    logic                init_done_q, init_done_d;
    logic [CNT_W-1:0]    wr_count_q, wr_count_d;
    logic                grant_a, grant_b;

`ifdef REGFILE_WB_PENDING_EN
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                collision_q, collision_d;
`endif

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        grant_id_d   = grant_id_q;
        init_done_d  = 1'b0;
        grant_a      = 1'b0;
        grant_b      = 1'b0;

        case (state_q)
            StIdle: begin
                if (init_start) begin
                    state_d = StInit;
                    cnt_d   = '0;
                    prio_d  = 1'b0;
                end else if (!stall) begin
                    // Contention follows the pointer; a lone requester never moves it.
                    if (a_valid && b_valid) begin
                        grant_a = ~prio_q;
                        grant_b = prio_q;
                        prio_d  = ~prio_q;
                    end else begin
                        grant_a = a_valid;
                        grant_b = b_valid;
                    end
                end

                if (grant_a) begin
                    reg_write_d  = 1'b1;
                    write_reg_d  = a_reg;
                    write_data_d = a_data;
                    grant_id_d   = 1'b0;
                end else if (grant_b) begin
                    reg_write_d  = 1'b1;
                    write_reg_d  = b_reg;
                    write_data_d = b_data;
                    grant_id_d   = 1'b1;
                end
            end

            StInit: begin
                if (!stall) begin
                    reg_write_d  = 1'b1;
                    write_reg_d  = cnt_q;
                    write_data_d = '0;
                    grant_id_d   = 1'b0;
                    cnt_d        = cnt_q + ADDR_W'(1);
                    // Registered so it lands with the final address write.
                    if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                        state_d     = StDone;
                        init_done_d = 1'b1;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        wr_count_d = wr_count_q + CNT_W'(reg_write_d);
    end

`ifdef REGFILE_WB_PENDING_EN
    always_comb begin
        pending_d = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            pending_d[i] = reg_write_d && (write_reg_d == ADDR_W'(i));
        end
        collision_d = (grant_a || grant_b) && a_valid && b_valid && (a_reg == b_reg);
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            grant_id_q   <= 1'b0;
            init_done_q  <= 1'b0;
            wr_count_q   <= '0;
`ifdef REGFILE_WB_PENDING_EN
            pending_q    <= '0;
            collision_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            grant_id_q   <= grant_id_d;
            init_done_q  <= init_done_d;
            wr_count_q   <= wr_count_d;
`ifdef REGFILE_WB_PENDING_EN
            pending_q    <= pending_d;
            collision_q  <= collision_d;
`endif
        end
    end

    assign a_ready   = grant_a && !reset;
    assign b_ready   = grant_b && !reset;
    assign RegWrite  = reg_write_q;
    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;
    assign grant_id  = grant_id_q;
    assign init_done = init_done_q;
    assign wr_count  = wr_count_q;
`ifdef REGFILE_WB_PENDING_EN
    assign pending_mask = pending_q;
    assign collision    = collision_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; checks pending_mask/collision when
// REGFILE_WB_PENDING_EN is defined.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0]  a_reg = '0, b_reg = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        stall = 1'b0, init_start = 1'b0;
    logic        a_ready, b_ready, init_done, RegWrite, grant_id;
    logic [1:0]  WriteReg;
    logic [31:0] WriteData;
    logic [15:0] wr_count;
`ifdef REGFILE_WB_PENDING_EN
    logic [3:0]  pending_mask;
    logic        collision;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = '0;
    logic [52:0] exp_o;
    logic [1:0]  exp_r;

    wire  [52:0] outs = {RegWrite, grant_id, init_done, WriteReg, WriteData, wr_count};
    wire  [1:0]  rdys = {a_ready, b_ready};

    regfile_wb_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_reg      (a_reg),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_reg      (b_reg),
        .b_data     (b_data),
        .stall      (stall),
        .init_start (init_start),
        .init_done  (init_done),
        .RegWrite   (RegWrite),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .grant_id   (grant_id),
`ifdef REGFILE_WB_PENDING_EN
        .pending_mask (pending_mask),
        .collision    (collision),
`endif
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic av, input logic [1:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [1:0] br, input logic [31:0] bd,
                         input logic st, input logic is);
        @(negedge clk);
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        stall = st; init_start = is;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1, 2'd2, 32'h1234, 1, 2'd1, 32'h5678, 0, 0);
            n_cmp++; if (rdys !== 2'b00) begin n_fail++;
                $display("FAIL reset_ready got=%b exp=00", rdys); end
            tick();
            exp_o = {1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 16'd0};
            n_cmp++; if (outs !== exp_o) begin n_fail++;
                $display("FAIL reset_outs got=%h exp=%h", outs, exp_o); end
        end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL reset_dropped got=%h exp=%h", outs, exp_o); end
    endtask

    task automatic test_single_a;
        drive(1, 2'd2, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        n_cmp++; if (rdys !== 2'b10) begin n_fail++;
            $display("FAIL single_ready got=%b exp=10", rdys); end
        tick();
        exp_cnt = 16'd1;
        exp_o = {1'b1, 1'b0, 1'b0, 2'd2, 32'hDEADBEEF, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL single_write got=%h exp=%h", outs, exp_o); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        exp_o = {1'b0, 1'b0, 1'b0, 2'd2, 32'hDEADBEEF, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL single_hold got=%h exp=%h", outs, exp_o); end
    endtask

    task automatic test_alternate;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'd1, 32'd11, 1, 2'd3, 32'd33, 0, 0);
            exp_r = (i % 2 == 0) ? 2'b10 : 2'b01;
            n_cmp++; if (rdys !== exp_r) begin n_fail++;
                $display("FAIL alt_ready[%0d] got=%b exp=%b", i, rdys, exp_r); end
            tick();
            exp_cnt++;
            exp_o = (i % 2 == 0) ? {1'b1, 1'b0, 1'b0, 2'd1, 32'd11, exp_cnt}
                                 : {1'b1, 1'b1, 1'b0, 2'd3, 32'd33, exp_cnt};
            n_cmp++; if (outs !== exp_o) begin n_fail++;
                $display("FAIL alt_write[%0d] got=%h exp=%h", i, outs, exp_o); end
        end
    endtask

    task automatic test_stall;
        drive(1, 2'd1, 32'd11, 1, 2'd3, 32'd33, 0, 0);
        tick();
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'd1, 32'd11, 1, 2'd3, 32'd33, 1, 0);
            n_cmp++; if (rdys !== 2'b00) begin n_fail++;
                $display("FAIL stall_ready[%0d] got=%b exp=00", i, rdys); end
            tick();
            exp_o = {1'b0, 1'b0, 1'b0, 2'd1, 32'd11, exp_cnt};
            n_cmp++; if (outs !== exp_o) begin n_fail++;
                $display("FAIL stall_outs[%0d] got=%h exp=%h", i, outs, exp_o); end
        end
        drive(1, 2'd1, 32'd11, 1, 2'd3, 32'd33, 0, 0);
        n_cmp++; if (rdys !== 2'b01) begin n_fail++;
            $display("FAIL stall_release_ready got=%b exp=01", rdys); end
        tick();
        exp_cnt++;
        exp_o = {1'b1, 1'b1, 1'b0, 2'd3, 32'd33, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL stall_release_write got=%h exp=%h", outs, exp_o); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_init;
        drive(0, 0, 0, 1, 2'd2, 32'h55, 0, 1);
        n_cmp++; if (rdys !== 2'b00) begin n_fail++;
            $display("FAIL init_start_ready got=%b exp=00", rdys); end
        tick();
        exp_o = {1'b0, 1'b1, 1'b0, 2'd3, 32'd33, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL init_start_outs got=%h exp=%h", outs, exp_o); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 2'd2, 32'h55, 0, 0);
            n_cmp++; if (rdys !== 2'b00) begin n_fail++;
                $display("FAIL init_ready[%0d] got=%b exp=00", i, rdys); end
            tick();
            exp_cnt++;
            exp_o = {1'b1, 1'b0, (i == 3), 2'(i), 32'd0, exp_cnt};
            n_cmp++; if (outs !== exp_o) begin n_fail++;
                $display("FAIL init_write[%0d] got=%h exp=%h", i, outs, exp_o); end
        end
        drive(0, 0, 0, 1, 2'd2, 32'h55, 0, 0);
        n_cmp++; if (rdys !== 2'b00) begin n_fail++;
            $display("FAIL done_ready got=%b exp=00", rdys); end
        tick();
        exp_o = {1'b0, 1'b0, 1'b0, 2'd3, 32'd0, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL done_outs got=%h exp=%h", outs, exp_o); end
        drive(0, 0, 0, 1, 2'd2, 32'h55, 0, 0);
        n_cmp++; if (rdys !== 2'b01) begin n_fail++;
            $display("FAIL post_init_ready got=%b exp=01", rdys); end
        tick();
        exp_cnt++;
        exp_o = {1'b1, 1'b1, 1'b0, 2'd2, 32'h55, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL post_init_write got=%h exp=%h", outs, exp_o); end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_same_reg;
        drive(1, 2'd1, 32'hAAAA, 1, 2'd1, 32'hBBBB, 0, 0);
        n_cmp++; if (rdys !== 2'b10) begin n_fail++;
            $display("FAIL same_ready_a got=%b exp=10", rdys); end
        tick();
        exp_cnt++;
        exp_o = {1'b1, 1'b0, 1'b0, 2'd1, 32'hAAAA, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL same_write_a got=%h exp=%h", outs, exp_o); end
`ifdef REGFILE_WB_PENDING_EN
        n_cmp++; if ({pending_mask, collision} !== 5'b0010_1) begin n_fail++;
            $display("FAIL same_pend_a got=%b exp=00101", {pending_mask, collision}); end
`endif
        drive(0, 0, 0, 1, 2'd1, 32'hBBBB, 0, 0);
        n_cmp++; if (rdys !== 2'b01) begin n_fail++;
            $display("FAIL same_ready_b got=%b exp=01", rdys); end
        tick();
        exp_cnt++;
        exp_o = {1'b1, 1'b1, 1'b0, 2'd1, 32'hBBBB, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL same_write_b got=%h exp=%h", outs, exp_o); end
`ifdef REGFILE_WB_PENDING_EN
        n_cmp++; if ({pending_mask, collision} !== 5'b0010_0) begin n_fail++;
            $display("FAIL same_pend_b got=%b exp=00100", {pending_mask, collision}); end
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
`ifdef REGFILE_WB_PENDING_EN
        n_cmp++; if ({pending_mask, collision} !== 5'b0000_0) begin n_fail++;
            $display("FAIL same_pend_idle got=%b exp=00000", {pending_mask, collision}); end
`endif
    endtask

    task automatic test_reset_mid_init;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
        end
        reset = 1'b1;
        drive(1, 2'd1, 32'h77, 0, 0, 0, 0, 0);
        n_cmp++; if (rdys !== 2'b00) begin n_fail++;
            $display("FAIL midreset_ready got=%b exp=00", rdys); end
        tick();
        exp_cnt = '0;
        exp_o = {1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 16'd0};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL midreset_outs got=%h exp=%h", outs, exp_o); end
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL midreset_no_done got=%h exp=%h", outs, exp_o); end
        drive(1, 2'd1, 32'h77, 0, 0, 0, 0, 0);
        n_cmp++; if (rdys !== 2'b10) begin n_fail++;
            $display("FAIL midreset_a_ready got=%b exp=10", rdys); end
        tick();
        exp_cnt = 16'd1;
        exp_o = {1'b1, 1'b0, 1'b0, 2'd1, 32'h77, exp_cnt};
        n_cmp++; if (outs !== exp_o) begin n_fail++;
            $display("FAIL midreset_a_write got=%h exp=%h", outs, exp_o); end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_alternate();
        test_stall();
        test_init();
        test_same_reg();
        test_reset_mid_init();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 4x32 register file.
- Shares that port between two writeback requesters, A (ALU) and B (load), using valid/ready handshakes and round-robin priority.
- Provides an init sequencer that clears every register through the write port.
- All regfile-side outputs are registered and drive RegWrite/WriteReg/WriteData directly.

Parameters:
- NUM_REGS, 4, number of registers in the file.
- ADDR_W, 2, register address width; NUM_REGS <= 2**ADDR_W.
- DATA_W, 32, write data width.
- CNT_W, 16, width of the write counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A handshake accepted this cycle (combinational).
- a_reg  in  ADDR_W  A destination register.
- a_data  in  DATA_W  A write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B handshake accepted this cycle (combinational).
- b_reg  in  ADDR_W  B destination register.
- b_data  in  DATA_W  B write data.
- stall  in  1  freeze; no grants while high.
- init_start  in  1  one-cycle pulse; starts the clear sequence.
- init_done  out  1  one-cycle pulse at the end of the clear sequence.
- RegWrite  out  1  regfile write enable.
- WriteReg  out  ADDR_W  regfile write address.
- WriteData  out  DATA_W  regfile write data.
- grant_id  out  1  source of the current RegWrite: 0 = A, 1 = B.
- wr_count  out  CNT_W  total regfile writes issued; wraps modulo 2**CNT_W.

Behaviour:
- Reset values (applied on any clk edge with reset=1):
  - RegWrite=0, WriteReg=0, WriteData=0, grant_id=0, init_done=0, wr_count=0.
  - Priority pointer = A; FSM = IDLE.
  - a_ready and b_ready are forced to 0 while reset=1.
  - A handshake presented in a reset cycle is dropped.
  - Reset in the middle of INIT aborts it; init_done does not pulse.
- FSM states: IDLE, INIT, DONE.
- IDLE, arbitration (only when stall=0 and init_start=0):
  - Only A valid -> a_ready=1.
  - Only B valid -> b_ready=1.
  - Both valid -> grant the side named by the priority pointer. The pointer then moves to the other side.
  - Single-requester grants leave the pointer unchanged.
  - Same rule applies when a_reg == b_reg: the loser waits and is written the following cycle, so the last write wins in grant order.
  - At most one ready is high in any cycle.
- Latency and outputs:
  - Handshake in cycle N -> RegWrite=1 in cycle N+1, with WriteReg, WriteData and grant_id from the granted requester.
  - No grant in N -> RegWrite=0 in N+1; WriteReg, WriteData and grant_id hold their values.
- wr_count increments by 1 on every cycle in which RegWrite=1, including INIT writes.
- stall=1:
  - Both readies are 0.
  - RegWrite=0 next cycle.
  - Pointer is unchanged.
  - INIT progress freezes; the address counter holds.
- init_start=1 in IDLE:
  - Takes precedence over requesters; no grant in that cycle.
  - Next state is INIT with the address counter at 0.
- init_start outside IDLE is ignored.
- INIT:
  - Readies are 0.
  - Each non-stalled cycle issues one write: WriteReg=counter, WriteData=0, RegWrite=1 (registered, so it appears the next cycle), grant_id=0.
  - Counter increments; after address NUM_REGS-1 is issued, go to DONE.
- DONE:
  - Asserts init_done=1 for exactly one cycle; this coincides with RegWrite for the final address.
  - Returns to IDLE.
  - Readies are 0 in DONE.
  - Priority pointer is reset to A on entry to INIT.
- Requester data need not remain stable after a handshake.

Optional Feature:
- Macro: REGFILE_WB_PENDING_EN.
- When defined:
  - Adds output pending_mask [NUM_REGS-1:0].
  - It is the one-hot of WriteReg when RegWrite=1, else all zeros. It is registered in step with RegWrite, for hazard detection by the read stage.
  - Also adds output collision, which pulses 1 (registered, in step with RegWrite) whenever both valids were high with a_reg == b_reg.
- When undefined: neither port exists, and no corresponding logic is present.

Test Plan:
- Reset, then a_valid=1, a_reg=2, a_data=32'hDEADBEEF for 1 cycle -> a_ready=1 in that cycle; next cycle RegWrite=1, WriteReg=2, WriteData=DEADBEEF, grant_id=0, wr_count=1.
- A and B both valid continuously (A reg=1 data=11, B reg=3 data=33) -> grants alternate A,B,A,B starting with A; RegWrite high every cycle; wr_count=4 after 4 writes.
- stall=1 for 3 cycles with both valid -> a_ready=b_ready=0 and RegWrite=0 for those cycles. After release the pending priority side is granted first (pointer unchanged).
- init_start pulse while B valid -> b_ready=0 through INIT/DONE. RegWrite writes 0 to regs 0,1,2,3 on consecutive cycles; init_done pulses with the reg 3 write; B is granted in the first IDLE cycle after.
- Reset asserted during INIT after 2 writes -> all outputs at reset values next cycle; no init_done; subsequent A request is served normally.
- With REGFILE_WB_PENDING_EN, A reg=1 and B reg=1 both valid -> collision=1 alongside the A write and pending_mask=4'b0010; the B write follows with pending_mask=4'b0010 and collision=0.
